// File: rtl/prog_timer.sv
// Programmable up-counter with prescaler, terminal compare, periodic/one-shot modes.
// Optional down-counting support is enabled by defining PROG_TIMER_DOWN_EN.
module prog_timer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned PSC_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] period,
   input  logic [PSC_W-1:0] prescale,
   input  logic             oneshot,
`ifdef PROG_TIMER_DOWN_EN
   input  logic             down,
`endif
   output logic [WIDTH-1:0] data,
   output logic             tick,
   output logic             done
);

   logic [WIDTH-1:0] data_q, data_d;
   logic [PSC_W-1:0] psc_q, psc_d;
   logic             tick_q, tick_d;
   logic             done_q, done_d;
   logic             active;
   logic             step;
   logic             terminal;
   logic [WIDTH-1:0] next_count;
   logic [WIDTH-1:0] wrap_val;

   assign active = enable & ~done_q;
   // >= rather than == so a prescale lowered mid-count never waits for psc to wrap.
   assign step   = active & (psc_q >= prescale);

`ifdef PROG_TIMER_DOWN_EN
   assign terminal   = down ? (data_q == '0) : (data_q == period);
   assign next_count = down ? (data_q - WIDTH'(1)) : (data_q + WIDTH'(1));
   assign wrap_val   = down ? period : '0;
`else
   assign terminal   = (data_q == period);
   assign next_count = data_q + WIDTH'(1);
   assign wrap_val   = '0;
`endif

   always_comb begin
      data_d = data_q;
      psc_d  = psc_q;
      tick_d = 1'b0;
      done_d = done_q;
      if (clear) begin
         data_d = '0;
         psc_d  = '0;
         done_d = 1'b0;
      end else if (load) begin
         data_d = load_val;
         psc_d  = '0;
         done_d = 1'b0;
      end else if (step) begin
         psc_d = '0;
         if (terminal) begin
            tick_d = 1'b1;
            if (oneshot) begin
               done_d = 1'b1;
            end else begin
               data_d = wrap_val;
            end
         end else begin
            data_d = next_count;
         end
      end else if (active) begin
         psc_d = psc_q + PSC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q <= '0;
         psc_q  <= '0;
         tick_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         data_q <= data_d;
         psc_q  <= psc_d;
         tick_q <= tick_d;
         done_q <= done_d;
      end
   end

   assign data = data_q;
   assign tick = tick_q;
   assign done = done_q;

endmodule
